// File: rtl/multicycle_alu_if.sv
// Request/response bundle for multicycle_alu: operands and opcode in,
// registered result, flags and handshake out.
interface multicycle_alu_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic [2:0]            ALUop;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic [DATA_WIDTH-1:0] result;
  logic [DATA_WIDTH-1:0] result_hi;
  logic                  zero;
  logic                  div_by_zero;
  logic                  busy;
  logic                  done;

  modport master (
    output start, ALUop, a, b,
    input  result, result_hi, zero, div_by_zero, busy, done
  );

  modport slave (
    input  start, ALUop, a, b,
    output result, result_hi, zero, div_by_zero, busy, done
  );
endinterface

// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle logic/arith ops plus iterative shift-add
// multiply and restoring divide, one bit per clock.
module multicycle_alu #(
  parameter int DATA_WIDTH = 32
) (
  input  logic            clk,
  input  logic            reset,
  multicycle_alu_if.slave alu
);
  localparam int DW = DATA_WIDTH;
  localparam int CW = $clog2(DW);
  localparam logic [CW-1:0] LAST_ITER = CW'(DW - 1);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_MULU = 3'b011;
  localparam logic [2:0] OP_DIVU = 3'b100;
  localparam logic [2:0] OP_SLTU = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t        r_state;
  logic [CW-1:0] r_count;
  logic [DW-1:0] r_hi;     // partial product high half / running remainder
  logic [DW-1:0] r_lo;     // multiplier bits / dividend-then-quotient bits
  logic [DW-1:0] r_opnd;   // multiplicand / divisor
  logic [DW-1:0] r_result;
  logic [DW-1:0] r_result_hi;
  logic          r_zero;
  logic          r_dbz;
  logic          r_busy;
  logic          r_done;

  logic [DW-1:0] w_alu;
  logic [DW:0]   w_mul_sum;
  logic [DW-1:0] w_mul_hi_next;
  logic [DW-1:0] w_mul_lo_next;
  logic [DW:0]   w_div_shift;
  logic [DW:0]   w_div_diff;
  logic          w_div_ge;
  logic [DW-1:0] w_div_rem_next;
  logic [DW-1:0] w_div_quo_next;

  always_comb begin
    w_alu = '0;
    case (alu.ALUop)
      OP_AND:  w_alu = alu.a & alu.b;
      OP_OR:   w_alu = alu.a | alu.b;
      OP_ADD:  w_alu = alu.a + alu.b;
      OP_SUB:  w_alu = alu.a - alu.b;
      OP_SLT:  w_alu = {{(DW-1){1'b0}}, ($signed(alu.a) < $signed(alu.b))};
      OP_SLTU: w_alu = {{(DW-1){1'b0}}, (alu.a < alu.b)};
      default: w_alu = '0;
    endcase
  end

  // One shift-add step: the carry out of the add shifts into the high half.
  assign w_mul_sum     = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : {(DW+1){1'b0}});
  assign w_mul_hi_next = w_mul_sum[DW:1];
  assign w_mul_lo_next = {w_mul_sum[0], r_lo[DW-1:1]};

  // One restoring-divide step; bit DW of the difference is the borrow.
  assign w_div_shift    = {r_hi, r_lo[DW-1]};
  assign w_div_diff     = w_div_shift - {1'b0, r_opnd};
  assign w_div_ge       = ~w_div_diff[DW];
  assign w_div_rem_next = w_div_ge ? w_div_diff[DW-1:0] : w_div_shift[DW-1:0];
  assign w_div_quo_next = {r_lo[DW-2:0], w_div_ge};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_opnd      <= '0;
      r_result    <= '0;
      r_result_hi <= '0;
      r_zero      <= 1'b1;
      r_dbz       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (alu.start) begin
            r_busy  <= 1'b1;
            r_dbz   <= 1'b0;
            r_count <= '0;
            r_hi    <= '0;
            if (alu.ALUop == OP_MULU) begin
              r_state <= S_MUL;
              r_lo    <= alu.b;
              r_opnd  <= alu.a;
            end else if (alu.ALUop == OP_DIVU && alu.b != '0) begin
              r_state <= S_DIV;
              r_lo    <= alu.a;
              r_opnd  <= alu.b;
            end else if (alu.ALUop == OP_DIVU) begin
              r_state     <= S_DONE;
              r_result    <= '1;
              r_result_hi <= alu.a;
              r_zero      <= 1'b0;
              r_dbz       <= 1'b1;
              r_done      <= 1'b1;
            end else begin
              r_state     <= S_DONE;
              r_result    <= w_alu;
              r_result_hi <= '0;
              r_zero      <= (w_alu == '0);
              r_done      <= 1'b1;
            end
          end
        end
        S_MUL: begin
          r_hi    <= w_mul_hi_next;
          r_lo    <= w_mul_lo_next;
          r_count <= r_count + 1'b1;
          if (r_count == LAST_ITER) begin
            r_state     <= S_DONE;
            r_result    <= w_mul_lo_next;
            r_result_hi <= w_mul_hi_next;
            r_zero      <= (w_mul_lo_next == '0);
            r_done      <= 1'b1;
          end
        end
        S_DIV: begin
          r_hi    <= w_div_rem_next;
          r_lo    <= w_div_quo_next;
          r_count <= r_count + 1'b1;
          if (r_count == LAST_ITER) begin
            r_state     <= S_DONE;
            r_result    <= w_div_quo_next;
            r_result_hi <= w_div_rem_next;
            r_zero      <= (w_div_quo_next == '0);
            r_done      <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign alu.result      = r_result;
  assign alu.result_hi   = r_result_hi;
  assign alu.zero        = r_zero;
  assign alu.div_by_zero = r_dbz;
  assign alu.busy        = r_busy;
  assign alu.done        = r_done;
endmodule

// File: tb/tb_multicycle_alu.sv
// Directed bench for multicycle_alu: stimulus pushes expectations into a
// queue, an independent monitor pops and checks on every done pulse.
module tb_multicycle_alu;
  localparam int DW = 32;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic [31:0] hi;
    logic        zero;
    logic        dbz;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  logic prev_done = 1'b0;

  multicycle_alu_if #(.DATA_WIDTH(DW)) alu_if ();

  multicycle_alu #(.DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .alu   (alu_if.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (alu_if.done) begin
      if (prev_done) chk("done_single_cycle", 32'd1, 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_result"}, alu_if.result, e.res);
        chk({e.name, "_result_hi"}, alu_if.result_hi, e.hi);
        chk({e.name, "_zero"}, {31'd0, alu_if.zero}, {31'd0, e.zero});
        chk({e.name, "_dbz"}, {31'd0, alu_if.div_by_zero}, {31'd0, e.dbz});
        chk({e.name, "_latency"}, cyc, e.due);
        $display("txn %s result=%h result_hi=%h zero=%0b dbz=%0b cyc=%0d",
                 e.name, alu_if.result, alu_if.result_hi, alu_if.zero,
                 alu_if.div_by_zero, cyc);
      end
    end
    prev_done <= alu_if.done;
  end

  // Called at a negedge; returns one negedge later with start dropped.
  task automatic issue(input string name, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input logic [31:0] hi,
                       input logic zero, input logic dbz, input int lat,
                       input bit expect_done);
    exp_t e;
    alu_if.start = 1'b1;
    alu_if.ALUop = op;
    alu_if.a     = a;
    alu_if.b     = b;
    if (expect_done) begin
      e.name = name; e.res = res; e.hi = hi; e.zero = zero; e.dbz = dbz;
      e.due  = cyc + lat;
      sb.push_back(e);
    end
    @(negedge clk);
    alu_if.start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int exp_busy);
    int cnt = 0;
    while (alu_if.busy && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    chk({name, "_busy_cycles"}, cnt, exp_busy);
  endtask

  task automatic run(input string name, input logic [2:0] op,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] res, input logic [31:0] hi,
                     input logic zero, input logic dbz, input int lat);
    issue(name, op, a, b, res, hi, zero, dbz, lat, 1'b1);
    wait_idle(name, lat);
  endtask

  task automatic check_reset_state(input string name);
    chk({name, "_result"}, alu_if.result, 32'd0);
    chk({name, "_result_hi"}, alu_if.result_hi, 32'd0);
    chk({name, "_zero"}, {31'd0, alu_if.zero}, 32'd1);
    chk({name, "_dbz"}, {31'd0, alu_if.div_by_zero}, 32'd0);
    chk({name, "_busy"}, {31'd0, alu_if.busy}, 32'd0);
    chk({name, "_done"}, {31'd0, alu_if.done}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    alu_if.start = 1'b0;
    alu_if.ALUop = 3'b000;
    alu_if.a = '0;
    alu_if.b = '0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    reset = 1'b0;

    run("add_7_5",     3'b010, 32'd7,        32'd5,        32'd12,       32'd0, 1'b0, 1'b0, 1);
    run("sub_0_1",     3'b110, 32'd0,        32'd1,        32'hFFFFFFFF, 32'd0, 1'b0, 1'b0, 1);
    run("slt_m1_1",    3'b111, 32'hFFFFFFFF, 32'd1,        32'd1,        32'd0, 1'b0, 1'b0, 1);
    run("sltu_m1_1",   3'b101, 32'hFFFFFFFF, 32'd1,        32'd0,        32'd0, 1'b1, 1'b0, 1);
    run("sub_5_5",     3'b110, 32'd5,        32'd5,        32'd0,        32'd0, 1'b1, 1'b0, 1);
    run("and",         3'b000, 32'hF0F000FF, 32'h0FF00F0F, 32'h00F0000F, 32'd0, 1'b0, 1'b0, 1);
    run("or",          3'b001, 32'hF0000000, 32'h0000000F, 32'hF000000F, 32'd0, 1'b0, 1'b0, 1);
    run("add_wrap",    3'b010, 32'hFFFFFFFF, 32'd1,        32'd0,        32'd0, 1'b1, 1'b0, 1);
    run("mulu_m1_2",   3'b011, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFE, 32'd1, 1'b0, 1'b0, 33);
    run("divu_100_7",  3'b100, 32'd100,      32'd7,        32'd14,       32'd2, 1'b0, 1'b0, 33);
    run("divu_9_0",    3'b100, 32'd9,        32'd0,        32'hFFFFFFFF, 32'd9, 1'b0, 1'b1, 1);
    run("add_clr_dbz", 3'b010, 32'd1,        32'd1,        32'd2,        32'd0, 1'b0, 1'b0, 1);
    run("divu_big",    3'b100, 32'hFFFFFFFF, 32'h10,       32'h0FFFFFFF, 32'hF, 1'b0, 1'b0, 33);
    run("divu_5_9",    3'b100, 32'd5,        32'd9,        32'd0,        32'd5, 1'b1, 1'b0, 33);

    // MULU with a competing start mid-operation and again while in DONE.
    issue("mulu_ignore", 3'b011, 32'h00010000, 32'h00010000, 32'd0, 32'd1, 1'b1, 1'b0, 33, 1'b1);
    repeat (5) @(negedge clk);
    issue("mid_start", 3'b011, 32'd3, 32'd3, 32'd0, 32'd0, 1'b0, 1'b0, 0, 1'b0);
    repeat (26) @(negedge clk);
    if (alu_if.done) begin
      issue("done_start", 3'b010, 32'd8, 32'd8, 32'd0, 32'd0, 1'b0, 1'b0, 0, 1'b0);
    end else begin
      chk("mulu_ignore_done_at_33", {31'd0, alu_if.done}, 32'd1);
    end
    wait_idle("mulu_ignore_tail", 0);

    // Single-cycle op with start still high during DONE.
    issue("add_hold", 3'b010, 32'd20, 32'd22, 32'd42, 32'd0, 1'b0, 1'b0, 1, 1'b1);
    issue("hold_start", 3'b110, 32'd1, 32'd9, 32'd0, 32'd0, 1'b0, 1'b0, 0, 1'b0);
    wait_idle("add_hold_tail", 0);

    // Reset during DIVU iteration 10 abandons it; ADD accepted right after.
    issue("divu_abort", 3'b100, 32'd100, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0, 0, 1'b0);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_state("abort");
    reset = 1'b0;
    run("add_after_rst", 3'b010, 32'd2, 32'd3, 32'd5, 32'd0, 1'b0, 1'b0, 1);

    repeat (40) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
